snake_engine: RTL and testbench

Circular-buffer snake body engine. Successor to the shift-through-RAM snake block: per step it is O(length), not O(H*V). It adds growth, selectable wrap or wall mode, reversal rejection, a MAX_LEN-bounded body and a random-access read port for the renderer. It sits between the game-control FSM (step/dir/grow) and the VGA pixel generator (rd_idx lookups).

---
 rtl/snake_pkg.sv | 20 ++
 rtl/snake_next_cell.sv | 62 ++++++
 rtl/snake_engine.sv | 174 +++++++++++++++++
 tb/tb_snake_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine: directions, FSM states and
// the width helper used to size ports from grid and capacity parameters.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, FIN} state_t;

  // ceil(log2(n)) with a floor of one bit so single-value ranges still get a port
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/snake_next_cell.sv
// Combinational neighbour of a grid cell in a given direction, with either
// toroidal wrap or an out-of-grid flag when the move crosses an edge.
module snake_next_cell
  import snake_pkg::*;
#(
  parameter  int H    = 32,
  parameter  int V    = 32,
  parameter  int WRAP = 1,
  localparam int XW   = clog2w(H),
  localparam int YW   = clog2w(V)
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [1:0]    i_dir,
  output logic [XW-1:0] o_nx,
  output logic [YW-1:0] o_ny,
  output logic          o_oog
);

  localparam logic EDGE_IS_WALL = (WRAP == 0);

  always_comb begin
    o_nx  = i_x;
    o_ny  = i_y;
    o_oog = 1'b0;
    case (i_dir)
      DIR_RIGHT: begin
        if (i_x == XW'(H - 1)) begin
          o_nx  = '0;
          o_oog = EDGE_IS_WALL;
        end else begin
          o_nx = i_x + XW'(1);
        end
      end
      DIR_UP: begin
        if (i_y == YW'(V - 1)) begin
          o_ny  = '0;
          o_oog = EDGE_IS_WALL;
        end else begin
          o_ny = i_y + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (i_x == '0) begin
          o_nx  = XW'(H - 1);
          o_oog = EDGE_IS_WALL;
        end else begin
          o_nx = i_x - XW'(1);
        end
      end
      default: begin
        if (i_y == '0) begin
          o_ny  = YW'(V - 1);
          o_oog = EDGE_IS_WALL;
        end else begin
          o_ny = i_y - YW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_engine.sv
// Circular-buffer snake body: per step it scans the body once for self
// collision, then prepends the new head by moving the head pointer back.
module snake_engine
  import snake_pkg::*;
#(
  parameter  int H        = 32,
  parameter  int V        = 32,
  parameter  int MAX_LEN  = 64,
  parameter  int INIT_LEN = 3,
  parameter  int WRAP     = 1,
  localparam int XW       = clog2w(H),
  localparam int YW       = clog2w(V),
  localparam int IW       = clog2w(MAX_LEN),
  localparam int LW       = clog2w(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_step,
  input  logic [1:0]    i_dir,
  input  logic          i_grow,
  output logic          o_busy,
  output logic          o_done,
  input  logic [IW-1:0] i_rd_idx,
  output logic [XW-1:0] o_rd_x,
  output logic [YW-1:0] o_rd_y,
  output logic          o_rd_valid,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  output logic [LW-1:0] o_length,
  output logic          o_self_col,
  output logic          o_wall_col,
  output logic          o_dead
);

  state_t        r_state, w_state_nx;
  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [IW-1:0] r_hp;
  logic [LW-1:0] r_len;
  logic [1:0]    r_dir;
  logic          r_self, r_wall;

  logic [1:0]    r_req_dir, r_eff_dir;
  logic          r_grow;
  logic [XW-1:0] r_nx;
  logic [YW-1:0] r_ny;
  logic [IW-1:0] r_scan_idx;
  logic [LW-1:0] r_scan_n;
  logic [XW-1:0] r_rd_x;
  logic [YW-1:0] r_rd_y;
  logic          r_rd_valid;

  logic [1:0]    w_eff_dir;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_oog, w_hit, w_scan_last, w_grow_eff, w_accept;
  logic [IW-1:0] w_scan_addr, w_rd_addr, w_new_hp;

  // (a + b) mod MAX_LEN for a < MAX_LEN and any b representable in IW bits
  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW+1:0] s;
    s = {2'b00, a} + {2'b00, b};
    if (s >= (IW+2)'(MAX_LEN)) s = s - (IW+2)'(MAX_LEN);
    if (s >= (IW+2)'(MAX_LEN)) s = s - (IW+2)'(MAX_LEN);
    return IW'(s);
  endfunction

  assign o_head_x   = r_seg_x[r_hp];
  assign o_head_y   = r_seg_y[r_hp];
  assign o_length   = r_len;
  assign o_self_col = r_self;
  assign o_wall_col = r_wall;
  assign o_dead     = r_self | r_wall;
  assign o_rd_x     = r_rd_x;
  assign o_rd_y     = r_rd_y;
  assign o_rd_valid = r_rd_valid;

  // A request for the exact opposite heading keeps the current one.
  assign w_eff_dir   = (r_req_dir == (r_dir ^ 2'b10)) ? r_dir : r_req_dir;
  assign w_grow_eff  = i_grow && (r_len < LW'(MAX_LEN));
  assign w_accept    = (r_state == IDLE) && i_step && !o_dead;
  assign w_scan_addr = idx_add(r_hp, r_scan_idx);
  assign w_hit       = (r_seg_x[w_scan_addr] == r_nx) && (r_seg_y[w_scan_addr] == r_ny);
  assign w_scan_last = (LW'(r_scan_idx) + LW'(1)) == r_scan_n;
  assign w_new_hp    = (r_hp == '0) ? IW'(MAX_LEN - 1) : r_hp - IW'(1);
  assign w_rd_addr   = idx_add(r_hp, i_rd_idx);

  snake_next_cell #(.H(H), .V(V), .WRAP(WRAP)) u_next (
    .i_x   (o_head_x),
    .i_y   (o_head_y),
    .i_dir (w_eff_dir),
    .o_nx  (w_nx),
    .o_ny  (w_ny),
    .o_oog (w_oog)
  );

  always_comb begin
    w_state_nx = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      IDLE:   if (w_accept) w_state_nx = CALC;
      CALC: begin
        o_busy     = 1'b1;
        w_state_nx = w_oog ? FIN : SCAN;
      end
      SCAN: begin
        o_busy = 1'b1;
        if (w_hit)            w_state_nx = FIN;
        else if (w_scan_last) w_state_nx = COMMIT;
      end
      COMMIT: begin
        o_busy     = 1'b1;
        w_state_nx = FIN;
      end
      FIN: begin
        o_done     = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Committed body state and sticky collision flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < INIT_LEN; i++) begin
        r_seg_x[i] <= XW'(H / 2 - i);
        r_seg_y[i] <= YW'(V / 2);
      end
      r_hp       <= '0;
      r_len      <= LW'(INIT_LEN);
      r_dir      <= DIR_RIGHT;
      r_self     <= 1'b0;
      r_wall     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= LW'(i_rd_idx) < r_len;
      if (r_state == CALC && w_oog) r_wall <= 1'b1;
      if (r_state == SCAN && w_hit) r_self <= 1'b1;
      if (r_state == COMMIT) begin
        r_seg_x[w_new_hp] <= r_nx;
        r_seg_y[w_new_hp] <= r_ny;
        r_hp              <= w_new_hp;
        r_dir             <= r_eff_dir;
        r_len             <= r_len + LW'(r_grow);
      end
    end
  end

  // Per-step working registers and the read-port data path
  always_ff @(posedge clk) begin
    r_rd_x <= r_seg_x[w_rd_addr];
    r_rd_y <= r_seg_y[w_rd_addr];
    if (w_accept) begin
      r_req_dir  <= i_dir;
      r_grow     <= w_grow_eff;
      r_scan_n   <= w_grow_eff ? r_len : r_len - LW'(1);
      r_scan_idx <= '0;
    end
    if (r_state == CALC) begin
      r_nx      <= w_nx;
      r_ny      <= w_ny;
      r_eff_dir <= w_eff_dir;
    end
    if (r_state == SCAN) r_scan_idx <= r_scan_idx + IW'(1);
  end

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a wrapping 64-segment instance and a walled
// 6-segment instance share stimulus and are each compared to a body-list model.
module tb_snake_engine;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset, step, grow;
  logic [1:0] dir;
  logic [5:0] rd_idx_a;
  logic [2:0] rd_idx_b;

  logic       busy_a, done_a, rd_valid_a, self_a, wall_a, dead_a;
  logic [4:0] rd_x_a, rd_y_a, head_x_a, head_y_a;
  logic [6:0] len_a;
  logic       busy_b, done_b, rd_valid_b, self_b, wall_b, dead_b;
  logic [4:0] rd_x_b, rd_y_b, head_x_b, head_y_b;
  logic [2:0] len_b;

  always #5 clk = ~clk;

  snake_engine #(.H(32), .V(32), .MAX_LEN(64), .INIT_LEN(3), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .i_step(step), .i_dir(dir), .i_grow(grow),
    .o_busy(busy_a), .o_done(done_a), .i_rd_idx(rd_idx_a),
    .o_rd_x(rd_x_a), .o_rd_y(rd_y_a), .o_rd_valid(rd_valid_a),
    .o_head_x(head_x_a), .o_head_y(head_y_a), .o_length(len_a),
    .o_self_col(self_a), .o_wall_col(wall_a), .o_dead(dead_a)
  );

  snake_engine #(.H(32), .V(32), .MAX_LEN(6), .INIT_LEN(3), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .i_step(step), .i_dir(dir), .i_grow(grow),
    .o_busy(busy_b), .o_done(done_b), .i_rd_idx(rd_idx_b),
    .o_rd_x(rd_x_b), .o_rd_y(rd_y_b), .o_rd_valid(rd_valid_b),
    .o_head_x(head_x_b), .o_head_y(head_y_b), .o_length(len_b),
    .o_self_col(self_b), .o_wall_col(wall_b), .o_dead(dead_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Model: body as a list with the head at index 0.
  int bx [2][64];
  int by [2][64];
  int mlen [2];
  int mdir [2];
  int mself [2];
  int mwall [2];

  function automatic int maxl(input int m);
    return (m == 0) ? 64 : 6;
  endfunction

  task automatic model_reset(input int m);
    for (int i = 0; i < 3; i++) begin
      bx[m][i] = 16 - i;
      by[m][i] = 16;
    end
    mlen[m] = 3; mdir[m] = 0; mself[m] = 0; mwall[m] = 0;
  endtask

  // Returns the expected cycle of the done pulse counted from the accept edge (0 = ignored).
  task automatic model_step(input int m, input int d, input int g, output int lat);
    int ed, nx, ny, ge, n;
    lat = 0;
    if (mself[m] != 0 || mwall[m] != 0) return;
    ed = (d == (mdir[m] ^ 2)) ? mdir[m] : d;
    nx = bx[m][0] + ((ed == 0) ? 1 : 0) - ((ed == 2) ? 1 : 0);
    ny = by[m][0] + ((ed == 1) ? 1 : 0) - ((ed == 3) ? 1 : 0);
    if (nx < 0 || nx > 31 || ny < 0 || ny > 31) begin
      if (m == 0) begin
        nx = (nx + 32) % 32;
        ny = (ny + 32) % 32;
      end else begin
        mwall[m] = 1;
        lat = 2;
        return;
      end
    end
    ge = (g != 0 && mlen[m] < maxl(m)) ? 1 : 0;
    n  = (ge != 0) ? mlen[m] : mlen[m] - 1;
    for (int i = 0; i < n; i++) begin
      if (bx[m][i] == nx && by[m][i] == ny) begin
        mself[m] = 1;
        lat = 3 + i;
        return;
      end
    end
    for (int i = mlen[m] - 1 + ge; i > 0; i--) begin
      bx[m][i] = bx[m][i-1];
      by[m][i] = by[m][i-1];
    end
    bx[m][0] = nx; by[m][0] = ny;
    mlen[m] += ge;
    mdir[m] = ed;
    lat = 3 + n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  task automatic read_both(input int ia, input int ib);
    @(negedge clk);
    rd_idx_a = 6'(ia); rd_idx_b = 3'(ib);
    @(negedge clk);
    chk("A.rd_valid", int'(rd_valid_a), int'(ia < mlen[0]));
    if (ia < mlen[0]) begin
      chk("A.rd_x", int'(rd_x_a), bx[0][ia]);
      chk("A.rd_y", int'(rd_y_a), by[0][ia]);
    end
    chk("B.rd_valid", int'(rd_valid_b), int'(ib < mlen[1]));
    if (ib < mlen[1]) begin
      chk("B.rd_x", int'(rd_x_b), bx[1][ib]);
      chk("B.rd_y", int'(rd_y_b), by[1][ib]);
    end
  endtask

  task automatic read_a(input int idx, input int ex, input int ey, input int ev);
    @(negedge clk);
    rd_idx_a = 6'(idx);
    @(negedge clk);
    chk("A.rd_valid_const", int'(rd_valid_a), ev);
    if (ev != 0) begin
      chk("A.rd_x_const", int'(rd_x_a), ex);
      chk("A.rd_y_const", int'(rd_y_a), ey);
    end
  endtask

  task automatic check_state();
    chk("A.head_x", int'(head_x_a), bx[0][0]);
    chk("A.head_y", int'(head_y_a), by[0][0]);
    chk("A.length", int'(len_a), mlen[0]);
    chk("A.self_col", int'(self_a), mself[0]);
    chk("A.wall_col", int'(wall_a), mwall[0]);
    chk("A.dead", int'(dead_a), int'(mself[0] != 0 || mwall[0] != 0));
    chk("B.head_x", int'(head_x_b), bx[1][0]);
    chk("B.head_y", int'(head_y_b), by[1][0]);
    chk("B.length", int'(len_b), mlen[1]);
    chk("B.self_col", int'(self_b), mself[1]);
    chk("B.wall_col", int'(wall_b), mwall[1]);
    chk("B.dead", int'(dead_b), int'(mself[1] != 0 || mwall[1] != 0));
    read_both($urandom_range(0, 63), $urandom_range(0, 7));
    read_both(mlen[0] - 1, mlen[1] - 1);
  endtask

  task automatic do_step(input logic [1:0] d, input bit g, output int la, output int lb);
    int ea, eb, bound;
    model_step(0, int'(d), int'(g), ea);
    model_step(1, int'(d), int'(g), eb);
    @(negedge clk);
    step = 1'b1; dir = d; grow = g;
    @(negedge clk);
    step = 1'b0;
    la = 0; lb = 0;
    bound = ((ea > eb) ? ea : eb) + 2;
    if (bound < 4) bound = 4;
    for (int c = 1; c <= bound; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        chk("A.busy_after_step", int'(busy_a), int'(ea != 0));
        chk("B.busy_after_step", int'(busy_b), int'(eb != 0));
      end
      if (done_a && la == 0) la = c;
      if (done_b && lb == 0) lb = c;
    end
    chk("A.done_latency", la, ea);
    chk("B.done_latency", lb, eb);
    check_state();
  endtask

  int la, lb, seen;

  initial begin
    reset = 1'b1; step = 1'b0; dir = 2'd0; grow = 1'b0;
    rd_idx_a = '0; rd_idx_b = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Reset state
    chk("t1.busy", int'(busy_a), 0);
    chk("t1.done", int'(done_a), 0);
    chk("t1.length", int'(len_a), 3);
    chk("t1.dead", int'(dead_a), 0);
    chk("t1.head_x", int'(head_x_a), 16);
    chk("t1.head_y", int'(head_y_a), 16);
    read_a(0, 16, 16, 1);
    read_a(1, 15, 16, 1);
    read_a(2, 14, 16, 1);
    read_a(3, 0, 0, 0);

    // Plain turn up
    do_step(DIR_UP, 1'b0, la, lb);
    chk("t2.latency", la, 5);
    chk("t2.head_x", int'(head_x_a), 16);
    chk("t2.head_y", int'(head_y_a), 17);
    chk("t2.length", int'(len_a), 3);
    read_a(1, 16, 16, 1);
    read_a(2, 15, 16, 1);

    // Growth, then reversal rejection
    do_reset();
    do_step(DIR_RIGHT, 1'b1, la, lb);
    chk("t3.length", int'(len_a), 4);
    chk("t3.head_x", int'(head_x_a), 17);
    read_a(3, 14, 16, 1);
    do_step(DIR_LEFT, 1'b0, la, lb);
    chk("t3.rev_head_x", int'(head_x_a), 18);
    chk("t3.rev_head_y", int'(head_y_a), 16);

    // Right edge: wrap on A, wall on B
    do_reset();
    repeat (15) do_step(DIR_RIGHT, 1'b0, la, lb);
    chk("t4.edge_x", int'(head_x_a), 31);
    do_step(DIR_RIGHT, 1'b0, la, lb);
    chk("t4.wrap_x", int'(head_x_a), 0);
    chk("t4.wrap_y", int'(head_y_a), 16);
    chk("t4.wall_col", int'(wall_b), 1);
    chk("t4.wall_dead", int'(dead_b), 1);
    chk("t4.wall_head_x", int'(head_x_b), 31);
    chk("t4.wall_done", lb, 2);
    do_step(DIR_UP, 1'b0, la, lb);
    chk("t4.dead_ignored", lb, 0);

    // Self collision on a grown body
    do_reset();
    do_step(DIR_RIGHT, 1'b1, la, lb);
    do_step(DIR_RIGHT, 1'b1, la, lb);
    chk("t5.len5", int'(len_a), 5);
    chk("t5.head_x", int'(head_x_a), 18);
    do_step(DIR_UP, 1'b0, la, lb);
    do_step(DIR_LEFT, 1'b0, la, lb);
    do_step(DIR_DOWN, 1'b0, la, lb);
    chk("t5.self_col", int'(self_a), 1);
    chk("t5.self_latency", la, 6);
    chk("t5.len_kept", int'(len_a), 5);
    chk("t5.head_kept_x", int'(head_x_a), 17);

    // Square loop into the vacating tail
    do_reset();
    do_step(DIR_RIGHT, 1'b1, la, lb);
    do_step(DIR_UP, 1'b0, la, lb);
    do_step(DIR_LEFT, 1'b0, la, lb);
    do_step(DIR_DOWN, 1'b0, la, lb);
    chk("t5.loop_dead", int'(dead_a), 0);
    chk("t5.loop_head_x", int'(head_x_a), 16);
    chk("t5.loop_head_y", int'(head_y_a), 16);

    // Reset while scanning
    do_reset();
    @(negedge clk);
    step = 1'b1; dir = DIR_UP; grow = 1'b0;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("t6.busy_in_scan", int'(busy_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    chk("t6.busy", int'(busy_a), 0);
    chk("t6.head_x", int'(head_x_a), 16);
    chk("t6.head_y", int'(head_y_a), 16);
    chk("t6.length", int'(len_a), 3);
    seen = int'(done_a);
    repeat (6) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    chk("t6.no_done", seen, 0);

    // Random episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int s = 0; s < 25; s++)
        do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), la, lb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
